// File: rtl/rf_pkg.sv
// Shared defaults and drain-state encoding for the register-file writeback queue.
package rf_pkg;
  localparam int REG_WIDTH = 32;
  localparam int NAME_BITS = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    PULSE = 2'd2
  } rf_wb_state_t;
endpackage

// File: rtl/rf_bypass_match.sv
// Youngest-wins search of the occupied queue entries for one read index.
module rf_bypass_match #(
  parameter int REG_WIDTH = 32,
  parameter int NAME_BITS = 5,
  parameter int DEPTH     = 4,
  parameter int PW        = $clog2(DEPTH),
  parameter int CW        = $clog2(DEPTH) + 1
) (
  input  logic [DEPTH-1:0][NAME_BITS-1:0] ent_ws,
  input  logic [DEPTH-1:0][REG_WIDTH-1:0] ent_wd,
  input  logic [PW-1:0]                   head,
  input  logic [CW-1:0]                   count,
  input  logic [NAME_BITS-1:0]            rs,
  output logic                            hit,
  output logic [REG_WIDTH-1:0]            data
);
  logic [PW-1:0] idx;

  // Walk oldest to youngest so the last match left standing is the youngest.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if ((CW'(i) < count) && (rs != '0) && (ent_ws[idx] == rs)) begin
        hit  = 1'b1;
        data = ent_wd[idx];
      end
    end
  end
endmodule

// File: rtl/rf_writeback_queue.sv
// Writeback FIFO draining onto the split-strobe register file port,
// with a setup cycle ahead of every write pulse and two bypass lookups.
module rf_writeback_queue #(
  parameter int REG_WIDTH = rf_pkg::REG_WIDTH,
  parameter int NAME_BITS = rf_pkg::NAME_BITS,
  parameter int DEPTH     = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NAME_BITS-1:0]       in_ws,
  input  logic [REG_WIDTH-1:0]       in_wd,
  output logic                       write,
  output logic [NAME_BITS-1:0]       ws,
  output logic [REG_WIDTH-1:0]       wd,
  input  logic [NAME_BITS-1:0]       rs1,
  input  logic [NAME_BITS-1:0]       rs2,
  output logic                       byp1_hit,
  output logic                       byp2_hit,
  output logic [REG_WIDTH-1:0]       byp1_data,
  output logic [REG_WIDTH-1:0]       byp2_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);
  import rf_pkg::*;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0][NAME_BITS-1:0] q_ws;
  logic [DEPTH-1:0][REG_WIDTH-1:0] q_wd;
  logic [PW-1:0]                   head, tail, head_nxt;
  rf_wb_state_t                    state, state_n;
  logic                            write_n, push, pop;
  logic [NAME_BITS-1:0]            ws_n;
  logic [REG_WIDTH-1:0]            wd_n;

  assign in_ready = (count < CW'(DEPTH));
  assign empty    = (count == '0);
  // Index 0 requests are handshaken but dropped.
  assign push     = in_valid && in_ready && (in_ws != '0);
  assign pop      = (state == PULSE);
  assign head_nxt = head + PW'(1);

  always_comb begin
    state_n = state;
    write_n = 1'b0;
    ws_n    = ws;
    wd_n    = wd;
    case (state)
      IDLE: if (count != '0) begin
        state_n = SETUP;
        ws_n    = q_ws[head];
        wd_n    = q_wd[head];
      end
      SETUP: begin
        state_n = PULSE;
        write_n = 1'b1;
      end
      PULSE: begin
        if (count > CW'(1)) begin
          state_n = SETUP;
          ws_n    = q_ws[head_nxt];
          wd_n    = q_wd[head_nxt];
        end else if (push) begin
          // Last entry leaves while a new one arrives: forward it, storage is not yet written.
          state_n = SETUP;
          ws_n    = in_ws;
          wd_n    = in_wd;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      write <= 1'b0;
      ws    <= '0;
      wd    <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      state <= state_n;
      write <= write_n;
      ws    <= ws_n;
      wd    <= wd_n;
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head_nxt;
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_ws[tail] <= in_ws;
      q_wd[tail] <= in_wd;
    end
  end

  logic [1:0][NAME_BITS-1:0] rs_v;
  logic [1:0]                hit_v;
  logic [1:0][REG_WIDTH-1:0] data_v;

  assign rs_v = {rs2, rs1};

  for (genvar p = 0; p < 2; p++) begin : g_byp
    rf_bypass_match #(
      .REG_WIDTH(REG_WIDTH), .NAME_BITS(NAME_BITS), .DEPTH(DEPTH)
    ) u_match (
      .ent_ws(q_ws), .ent_wd(q_wd), .head(head), .count(count),
      .rs(rs_v[p]), .hit(hit_v[p]), .data(data_v[p])
    );
  end

  assign byp1_hit  = hit_v[0];
  assign byp2_hit  = hit_v[1];
  assign byp1_data = data_v[0];
  assign byp2_data = data_v[1];
endmodule
